// File: rtl/dmem_bytelane_if.sv
// Request/response bus of the byte-lane data memory.
// The master drives requests; the slave (memory) returns ready, responses and clear status.
interface dmem_bytelane_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_busy;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte/half/word data memory with post-reset hardware clear and pipelined read (1 or 2 cycles).
// Define DMEM_MISALIGN_ERR_EN to flag misaligned and size-3 accesses as errors instead of aligning them.
module dmem_bytelane #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RD_LATENCY  = 1
) (
    input logic            clk,
    input logic            reset,
    dmem_bytelane_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             ready_q, busy_q;
    logic             clr_we_c;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             acc_c;
    logic [IDX_W-1:0] idx_c;
    logic [1:0]       lane_c;
    logic [1:0]       size_c;
    logic             err_c;
    logic [3:0]       be_c;
    logic [31:0]      wsh_c;
    logic [31:0]      rd_word_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [31:0]      load_c;

    logic             v1_q;
    logic [31:0]      d1_q;
    logic             e1_q;

    logic             unused_addr_c;
    assign unused_addr_c = ^bus.req_addr[ADDR_W-1:IDX_W+2];

    // Clear sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_d == ST_RUN);
            busy_q  <= (state_d == ST_CLEAR);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_c = ~reset;
                ptr_d    = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign bus.req_ready = ready_q;
    assign bus.init_busy = busy_q;

    assign acc_c = bus.req_valid & ready_q & ~reset;
    assign idx_c = bus.req_addr[IDX_W+1:2];

    // Access size/lane normalisation and error detection
    always_comb begin
        size_c = bus.req_size;
        lane_c = bus.req_addr[1:0];
        err_c  = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        case (bus.req_size)
            2'd1:    err_c = bus.req_addr[0];
            2'd2:    err_c = (bus.req_addr[1:0] != 2'd0);
            2'd3:    err_c = 1'b1;
            default: err_c = 1'b0;
        endcase
`else
        case (bus.req_size)
            2'd1:    lane_c = {bus.req_addr[1], 1'b0};
            2'd2,
            2'd3: begin
                size_c = 2'd2;
                lane_c = 2'd0;
            end
            default: lane_c = bus.req_addr[1:0];
        endcase
`endif
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        be_c  = 4'b0000;
        wsh_c = '0;
        case (size_c)
            2'd0: begin
                be_c  = 4'b0001 << lane_c;
                wsh_c = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                be_c  = lane_c[1] ? 4'b1100 : 4'b0011;
                wsh_c = {2{bus.req_wdata[15:0]}};
            end
            2'd2: begin
                be_c  = 4'b1111;
                wsh_c = bus.req_wdata;
            end
            default: be_c = 4'b0000;
        endcase
        if (err_c || !bus.req_we) begin
            be_c = 4'b0000;
        end
    end

    // Load lane extraction and extension
    always_comb begin
        rd_word_c = mem_q[idx_c];
        byte_c    = rd_word_c[{lane_c, 3'b000} +: 8];
        half_c    = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        load_c    = '0;
        case (size_c)
            2'd0: load_c = bus.req_unsigned ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
            2'd1: load_c = bus.req_unsigned ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
            2'd2: load_c = rd_word_c;
            default: load_c = '0;
        endcase
        if (err_c || bus.req_we) begin
            load_c = '0;
        end
    end

    // Memory array: clear writes take priority, otherwise byte-enabled stores
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem_q[ptr_q] <= '0;
        end else if (acc_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= wsh_c[8*b +: 8];
                end
            end
        end
    end

    // First response stage, loaded at the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            e1_q <= 1'b0;
        end else begin
            v1_q <= acc_c;
            d1_q <= acc_c ? load_c : 32'd0;
            e1_q <= acc_c & err_c;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic        v2_q;
            logic [31:0] d2_q;
            logic        e2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                    e2_q <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    d2_q <= d1_q;
                    e2_q <= e1_q;
                end
            end

            assign bus.rsp_valid = v2_q;
            assign bus.rsp_rdata = d2_q;
            assign bus.rsp_err   = e2_q;
        end else begin : g_lat1
            assign bus.rsp_valid = v1_q;
            assign bus.rsp_rdata = d1_q;
            assign bus.rsp_err   = e1_q;
        end
    endgenerate
endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: one instance per read latency, shared stimulus,
// expectations from a byte-array reference model.
module tb_dmem_bytelane;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned BYTES = 4 * DEPTH;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t       q1[$];
    exp_t       q2[$];
    logic [7:0] mem_m [BYTES];

    dmem_bytelane_if #(.ADDR_W(32)) bus1 ();
    dmem_bytelane_if #(.ADDR_W(32)) bus2 ();

    dmem_bytelane #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    dmem_bytelane #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory as a flat byte array, addresses wrap modulo its size
    task automatic model(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output bit err);
        int a;
        int n;
        logic [31:0] v;
        a   = int'(addr % BYTES);
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        rd  = '0;
        err = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        if (size == 2'd3 || (a % n) != 0) begin
            err = 1'b1;
            return;
        end
`else
        a = a - (a % n);
`endif
        if (we) begin
            for (int i = 0; i < n; i++) mem_m[a+i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[a+i]) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            rd = v;
        end
    endtask

    task automatic set_req(input bit v, input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus1.req_valid = v;  bus2.req_valid = v;
        bus1.req_we = we;    bus2.req_we = we;
        bus1.req_size = size; bus2.req_size = size;
        bus1.req_unsigned = uns; bus2.req_unsigned = uns;
        bus1.req_addr = addr; bus2.req_addr = addr;
        bus1.req_wdata = wdata; bus2.req_wdata = wdata;
    endtask

    task automatic idle();
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    endtask

    // Present one request, hold it until ready, push expected responses for both latencies
    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit use_exp, input logic [31:0] exp_d, input bit exp_e);
        int   n;
        exp_t e;
        logic [31:0] rd;
        bit   err;
        @(negedge clk);
        set_req(1'b1, we, size, uns, addr, wdata);
        n = 0;
        while (!bus1.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus1.req_ready) begin
            chk("ready_timeout", 32'(n), 32'd0);
            return;
        end
        model(we, size, uns, addr, wdata, rd, err);
        e.data = use_exp ? exp_d : rd;
        e.err  = use_exp ? exp_e : err;
        e.cyc  = cyc + 1;
        q1.push_back(e);
        e.cyc  = cyc + 2;
        q2.push_back(e);
    endtask

    task automatic do_reset(input bit measure);
        int  cnt;
        bit  early_ready;
        @(negedge clk);
        #1;
        q1.delete();
        q2.delete();
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready1", 32'(bus1.req_ready), 32'd0);
        chk("rst_busy1", 32'(bus1.init_busy), 32'd1);
        chk("rst_rvalid1", 32'(bus1.rsp_valid), 32'd0);
        chk("rst_rdata1", bus1.rsp_rdata, 32'd0);
        chk("rst_err1", 32'(bus1.rsp_err), 32'd0);
        chk("rst_rvalid2", 32'(bus2.rsp_valid), 32'd0);
        chk("rst_busy2", 32'(bus2.init_busy), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < int'(BYTES); i++) mem_m[i] = 8'h00;
        if (measure) begin
            cnt = 0;
            early_ready = 1'b0;
            while (bus1.init_busy && cnt < 500) begin
                if (bus1.req_ready) early_ready = 1'b1;
                cnt++;
                @(negedge clk);
            end
            chk("clear_cycles", 32'(cnt), 32'(DEPTH));
            chk("ready_in_clear", 32'(early_ready), 32'd0);
            chk("ready_after_clear1", 32'(bus1.req_ready), 32'd1);
            chk("ready_after_clear2", 32'(bus2.req_ready), 32'd1);
        end
    endtask

    task automatic chk_rsp(input int lat, input logic [31:0] d, input logic e);
        exp_t x;
        if ((lat == 1 && q1.size() == 0) || (lat == 2 && q2.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp lat%0d: got data=%h err=%0b expected no response at cycle %0d",
                     lat, d, e, cyc);
            return;
        end
        x = (lat == 1) ? q1.pop_front() : q2.pop_front();
        chk($sformatf("rsp_data_lat%0d", lat), d, x.data);
        chk($sformatf("rsp_err_lat%0d", lat), 32'(e), 32'(x.err));
        chk($sformatf("rsp_cycle_lat%0d", lat), 32'(cyc), 32'(x.cyc));
    endtask

    // Monitor: pop and compare whenever either instance presents a response
    always @(negedge clk) begin
        if (!reset) begin
            if (bus1.rsp_valid === 1'b1) chk_rsp(1, bus1.rsp_rdata, bus1.rsp_err);
            if (bus2.rsp_valid === 1'b1) chk_rsp(2, bus2.rsp_rdata, bus2.rsp_err);
        end
    end

    initial begin
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        do_reset(1'b1);

        for (int i = 0; i < int'(DEPTH); i++) issue(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'd0, 1'b1, 32'd0, 1'b0);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000005A, 1'b1, 32'd0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDE5ABEEF, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 1'b1, 32'hFFFFFFDE, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b1, 32'h000000DE, 1'b0);

        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 1'b1, 32'd0, 1'b0);
        idle();
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 1'b1, 32'hFFFF8001, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 1'b1, 32'h00008001, 1'b0);

        issue(1'b1, 2'd2, 1'b0, 32'h04, 32'h12345678, 1'b1, 32'd0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 1'b1, 32'h12345678, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, 1'b1, 32'h12345678, 1'b0);

`ifdef DMEM_MISALIGN_ERR_EN
        issue(1'b1, 2'd2, 1'b0, 32'h06, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 1'b1, 32'h12345678, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 32'h04, 32'd0, 1'b1, 32'd0, 1'b1);
`else
        issue(1'b1, 2'd2, 1'b0, 32'h06, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDE5ABEEF, 1'b0);
`endif

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) idle();
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 1023)), $urandom, 1'b0, 32'd0, 1'b0);
        end

        // Reset while a load is in flight; request held through the clear must read 0
        issue(1'b1, 2'd2, 1'b0, 32'h04, 32'h12345678, 1'b1, 32'd0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 1'b1, 32'h12345678, 1'b0);
        do_reset(1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 1'b1, 32'd0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b1, 32'd0, 1'b0);

        for (int k = 0; k < 6; k++) idle();
        chk("drain_q1", 32'(q1.size()), 32'd0);
        chk("drain_q2", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
